// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, colour constants and the pixel colour type used
// by the scan controller and the renderers that feed it.
package vga_timing_pkg;

    localparam int COORD_W = 11;

    localparam int   DEF_CLK_DIV  = 4;
    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] GREEN  = 12'h0F0;
    localparam logic [11:0] BLUE   = 12'h00F;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] YELLOW = 12'hFF0;
    localparam logic [11:0] CYAN   = 12'h0FF;
    localparam logic [11:0] ROYAL  = 12'h46E;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: counts pixels (or lines) on each advance strobe and decodes
// the active region and sync window from the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE   = 640,
    parameter int   FP       = 16,
    parameter int   SYNC     = 96,
    parameter int   BP       = 48,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv_i,
    output logic [COORD_W-1:0] count_o,
    output logic               wrap_o,
    output logic               active_o,
    output logic               sync_o
);

    localparam logic [COORD_W-1:0] LAST       = COORD_W'(ACTIVE + FP + SYNC + BP - 1);
    localparam logic [COORD_W-1:0] ACT_END    = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(ACTIVE + FP + SYNC);

    logic [COORD_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign count_o  = cnt_q;
    assign wrap_o   = adv_i && (cnt_q == LAST);
    assign active_o = (cnt_q < ACT_END);
    assign sync_o   = ((cnt_q >= SYNC_START) && (cnt_q < SYNC_END)) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA timing master: pixel-enable divider, scan coordinates, and registered
// RGB/sync pins one pixel behind the coordinates. Optional VGA_SCAN_BORDER_EN.
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        VGA_data,
    output logic [COORD_W-1:0] VGA_xpos,
    output logic [COORD_W-1:0] VGA_ypos,
    output logic               pix_en,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0]   div_q, div_d;
    logic               first_q, first_d;
    rgb444_t            rgb_q, rgb_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic               h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
    ) u_h_axis (
        .clk(clk), .rst(rst), .adv_i(pix_en),
        .count_o(h_cnt), .wrap_o(h_wrap), .active_o(h_active), .sync_o(h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
    ) u_v_axis (
        .clk(clk), .rst(rst), .adv_i(h_wrap),
        .count_o(v_cnt), .wrap_o(v_wrap), .active_o(v_active), .sync_o(v_sync)
    );

    assign pix_en      = (div_q == DIV_W'(CLK_DIV - 1));
    // first_q flags the pixel right after reset so it also counts as a frame start
    assign frame_start = pix_en && (v_wrap || first_q);

    always_comb begin
        div_d   = pix_en ? '0 : div_q + 1'b1;
        first_d = first_q && !pix_en;
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (pix_en) begin
            rgb_d = (h_active && v_active) ? rgb444_t'(VGA_data) : rgb444_t'(BLACK);
`ifdef VGA_SCAN_BORDER_EN
            if (h_active && v_active &&
                (h_cnt == '0 || h_cnt == COORD_W'(H_ACTIVE - 1) ||
                 v_cnt == '0 || v_cnt == COORD_W'(V_ACTIVE - 1))) begin
                rgb_d = rgb444_t'(WHITE);
            end
`endif
            hsync_d = h_sync;
            vsync_d = v_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            first_q <= 1'b1;
            rgb_q   <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else begin
            div_q   <= div_d;
            first_q <= first_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign VGA_xpos = h_cnt;
    assign VGA_ypos = v_cnt;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign vga_r    = rgb_q.r;
    assign vga_g    = rgb_q.g;
    assign vga_b    = rgb_q.b;

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- VGA display timing master that sits opposite every pixel renderer in the design.
- Generates the scan coordinates VGA_xpos/VGA_ypos that renderers such as the start-show, map and tank/bullet painters consume.
- Samples their merged 12-bit VGA_data and drives hsync, vsync and the 4:4:4 RGB pins.
- Produces 640x480@60 from a 100 MHz system clock by pixel-enable division.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=2)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, hsync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vsync width, lines
V_BP, 33, vertical back porch, lines
SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
clk  in  1  system clock; one clock domain only
rst  in  1  synchronous, active-high reset
VGA_data  in  12  pixel colour from renderers, {R[3:0],G[3:0],B[3:0]}
VGA_xpos  out  11  current horizontal count, 0..H_TOTAL-1
VGA_ypos  out  11  current vertical count, 0..V_TOTAL-1
pix_en  out  1  one-clk pulse per pixel period
frame_start  out  1  one-clk pulse at start of each frame
hsync  out  1  horizontal sync pin
vsync  out  1  vertical sync pin
vga_r  out  4  red pin
vga_g  out  4  green pin
vga_b  out  4  blue pin

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider div_cnt runs 0..CLK_DIV-1 and wraps. pix_en=1 exactly when div_cnt==CLK_DIV-1.
- h_cnt advances on pix_en and wraps H_TOTAL-1 -> 0. On that wrap, v_cnt advances and wraps V_TOTAL-1 -> 0.
- VGA_xpos = h_cnt, VGA_ypos = v_cnt, zero-extended to 11 bits. Both are stable for all CLK_DIV clocks of a pixel.
- Renderers therefore have CLK_DIV-1 clocks of latency budget (1-clk register paths and 2-clk ROM paths both fit).
- On the pix_en clock, output registers sample the pixel (h_cnt,v_cnt) that is ending:
  - active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)
  - {vga_r,vga_g,vga_b} <= active ? VGA_data : 12'h000
  - hsync <= (h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)) ? SYNC_POL : ~SYNC_POL; default window is [656,752)
  - vsync <= same rule on v_cnt; default window is [490,492)
- Pins are therefore delayed exactly one pixel period relative to the coordinates, uniformly for RGB and syncs.
- frame_start=1 for one clk, coincident with the pix_en on which h_cnt and v_cnt both wrap to 0. It is also asserted on the first pix_en after reset.
- Reset values:
  - div_cnt=0, h_cnt=0, v_cnt=0
  - hsync=vsync=~SYNC_POL
  - vga_r/g/b=0
  - pix_en=0, frame_start=0
- Reset mid-frame: the next clk after rst deasserts starts pixel (0,0) with a full CLK_DIV window. No partial sync pulse is extended.
- VGA_data outside the active region is ignored. Pins are forced black regardless.
- No back-pressure and no handshake: the renderer must meet the budget, and late data is simply sampled as-is.

Optional Feature:
Macro VGA_SCAN_BORDER_EN.
- Defined: an active pixel with h_cnt==0, h_cnt==H_ACTIVE-1, v_cnt==0 or v_cnt==V_ACTIVE-1 drives 12'hFFF (white), overriding VGA_data. This is the monitor alignment aid.
- Undefined: no override. Behaviour is exactly as above, with no extra logic.

Decomposition:
- Package vga_timing_pkg:
  - default timing constants
  - H_TOTAL/V_TOTAL derivation
  - colour constants (RED, GREEN, BLUE, WHITE, BLACK, YELLOW, CYAN, ROYAL as 12-bit values)
  - the 11-bit coordinate width
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical), each configured by ACTIVE/FP/SYNC/BP/SYNC_POL:
  - inputs: advance strobe
  - outputs: count, wrap pulse, active flag, sync level

Test Plan:
- Reset: hold rst 3 clks, release -> VGA_xpos=0, VGA_ypos=0, hsync=vsync=1, RGB=0. First pix_en at clk 4, with frame_start=1 on the same clk.
- Line timing: run 1 line -> 800 pix_en pulses (3200 clks) per line. hsync is low for exactly 96 pixels (384 clks), starting one pixel period after VGA_xpos reaches 656.
- Frame timing: run 2 frames -> frame_start pulses are 1,680,000 clks apart. vsync is low for exactly 2 lines (6400 clks), starting after VGA_ypos reaches 490.
- Data capture: VGA_data=12'hABC only while VGA_xpos=100, VGA_ypos=50 -> vga_r=A, vga_g=B, vga_b=C for that following pixel period, and 0 before/after.
- Blanking: VGA_data=12'hFFF held constant -> RGB=0 whenever the sampled xpos>=640 or ypos>=480.
- Mid-frame reset at VGA_xpos=300, VGA_ypos=200 -> next clk after release, counters=0, syncs deasserted, RGB=0. With VGA_SCAN_BORDER_EN defined and VGA_data=0, pixels at xpos 0/639 and ypos 0/479 drive 12'hFFF; all other pixels drive 0.
